time_unit_counter: RTL
======================

TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

Interface
REQ-001 Parameter MODULUS, default 60: count range 0..MODULUS-1; legal 2..100.
REQ-002 Parameter WIDTH, default 6: count width; SHALL satisfy 2**WIDTH >= MODULUS.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  count-step request; carry_out of the previous (less significant) stage in a cascade.
REQ-006 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous preset strobe.
REQ-008 load_val  input  WIDTH  preset value.
REQ-009 count  output  WIDTH  current binary count, registered.
REQ-010 bcd_tens  output  4  tens digit of count.
REQ-011 bcd_ones  output  4  ones digit of count.
REQ-012 carry_out  output  1  combinational step-through for the next stage.
REQ-013 rollover  output  1  registered one-cycle wrap pulse.
REQ-014 load_err  output  1  registered one-cycle pulse on a rejected load.

Function
REQ-015 Per-edge priority SHALL be: reset > load > enable > hold.
REQ-016 Load with load_val < MODULUS SHALL set count=load_val next cycle; enable that cycle ignored.
REQ-017 Load with load_val >= MODULUS SHALL leave count unchanged and pulse load_err high next cycle for one cycle.
REQ-018 enable=1, up_dn=1, count<MODULUS-1: count+1 next cycle.
REQ-019 enable=1, up_dn=1, count==MODULUS-1: count=0 next cycle.
REQ-020 enable=1, up_dn=0, count>0: count-1 next cycle.
REQ-021 enable=1, up_dn=0, count==0: count=MODULUS-1 next cycle.
REQ-022 enable=0 with no load: count SHALL hold.
REQ-023 carry_out SHALL equal enable AND NOT load AND terminal, same cycle, no register.
REQ-024 Terminal SHALL be MODULUS-1 when up_dn=1 and 0 when up_dn=0.
REQ-025 rollover SHALL be high the cycle after every wrap of REQ-019/REQ-021, else low.
REQ-026 up_dn may change any cycle; sampled each edge with enable.
REQ-027 bcd_tens/bcd_ones SHALL be combinational from count: tens = count/10, ones = count mod 10.
REQ-028 All arithmetic SHALL stay within WIDTH bits; count SHALL never exceed MODULUS-1.
REQ-029 Cascade: stage N+1 enable = stage N carry_out; all stages advance on the same edge, zero added latency.

Reset
REQ-030 reset=1 at a clock edge SHALL set count=0, rollover=0, load_err=0, regardless of load/enable.
REQ-031 While reset=1: carry_out SHALL be 0; bcd_tens=0 and bcd_ones=0 from the first edge.
REQ-032 Reset mid-sequence SHALL discard any pending wrap; no rollover pulse after reset release.

Structure
REQ-033 Shared package clock_pkg SHALL hold SEC_MOD=60, MIN_MOD=60, HR_MOD=24, and WIDTH constants for each.
REQ-034 Binary-to-two-digit BCD conversion SHALL be sub-module bin2bcd_2d (7-bit in, two 4-bit digits out, combinational).
REQ-035 The counter register, next-state logic and pulse registers SHALL stay in time_unit_counter.

Verification
REQ-036 MODULUS=60, reset, enable=1 up for 60 cycles -> count 0..59 then 0; carry_out high at 59; rollover high one cycle after.
REQ-037 MODULUS=24, up_dn=0 from count=0 with enable -> count=23, rollover pulse; bcd_tens=2, bcd_ones=3.
REQ-038 load=1, load_val=45, enable=1 same cycle -> count=45, no step, carry_out=0.
REQ-039 load_val=60 at MODULUS=60, count=12 -> count stays 12, load_err pulses one cycle.
REQ-040 Three-stage cascade 60/60/24 at 59:59:23, enable=1 -> all stages 0 on the same edge; hour rollover pulses.
REQ-041 Assert reset at count=59 with enable=1 -> count=0 next edge, rollover=0, carry_out=0 while reset high.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: moduli and widths shared by the seconds/minutes/hours counter stages
package clock_pkg;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD = 24;
  localparam int SEC_WIDTH = 6;
  localparam int MIN_WIDTH = 6;
  localparam int HR_WIDTH = 5;
  localparam int BCD_IN_W = 7;
endpackage

// File: rtl/bin2bcd_2d.sv
// bin2bcd_2d: combinational 7-bit binary to two BCD digits, valid for 0..99
module bin2bcd_2d (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  always_comb begin
    tens = '0;
    for (int i = 1; i < 10; i++) if (bin >= 7'(10 * i)) tens = 4'(i);
    ones = 4'(bin - 7'(tens) * 7'd10);
  end
endmodule

// File: rtl/time_unit_counter.sv
// time_unit_counter: cascadable modulo up/down counter with preset, BCD digits, carry and wrap pulses
module time_unit_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = SEC_MOD,
  parameter int WIDTH = SEC_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             carry_out,
  output logic             rollover,
  output logic             load_err
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic terminal, load_ok, step;
  logic [WIDTH-1:0] count_nxt;
  logic [BCD_IN_W-1:0] bin;
  assign terminal = up_dn ? count == MAX : count == '0;
  assign load_ok = 32'(load_val) < MODULUS;
  assign step = enable & ~load;
  // reset gates the carry so downstream stages never step while this stage is held in reset
  assign carry_out = step & ~reset & terminal;
  always_comb begin
    count_nxt = load ? (load_ok ? load_val : count)
              : step ? (terminal ? (up_dn ? '0 : MAX) : (up_dn ? count + 1'b1 : count - 1'b1))
              : count;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      rollover <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count <= count_nxt;
      rollover <= step & terminal;
      load_err <= load & ~load_ok;
    end
  end
  assign bin = BCD_IN_W'(count);
  bin2bcd_2d u_bcd (
    .bin (bin),
    .tens(bcd_tens),
    .ones(bcd_ones)
  );
endmodule
